// File: rtl/cache_2way_wb.sv
// 2-way set-associative write-back, write-allocate data cache with one LRU bit per set.
// Drop-in replacement for the direct-mapped cache: same processor and line-wide memory signalling.

module cache_2way_wb_way #(
  parameter int SET_BITS  = 2,
  parameter int WORD_BITS = 2,
  parameter int TAG_W     = 26,
  parameter int LINE_W    = 32 << WORD_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SET_BITS-1:0]  set_idx,
  output logic                 valid,
  output logic                 dirty,
  output logic [TAG_W-1:0]     tag,
  output logic [LINE_W-1:0]    line,
  input  logic                 fill_en,
  input  logic [TAG_W-1:0]     fill_tag,
  input  logic [LINE_W-1:0]    fill_line,
  input  logic                 clean_en,
  input  logic                 wr_en,
  input  logic [WORD_BITS-1:0] wr_word,
  input  logic [31:0]          wr_data
);
  localparam int SETS = 1 << SET_BITS;

  logic [SETS-1:0]   valid_q, dirty_q;
  logic [TAG_W-1:0]  tags  [SETS];
  logic [LINE_W-1:0] lines [SETS];

  assign valid = valid_q[set_idx];
  assign dirty = dirty_q[set_idx];
  assign tag   = tags[set_idx];
  assign line  = lines[set_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en) begin
      valid_q[set_idx] <= 1'b1;
      dirty_q[set_idx] <= 1'b0;
    end else if (clean_en) begin
      dirty_q[set_idx] <= 1'b0;
    end else if (wr_en) begin
      dirty_q[set_idx] <= 1'b1;
    end
  end

  // Tag/data storage is qualified by valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tags[set_idx]  <= fill_tag;
      lines[set_idx] <= fill_line;
    end else if (wr_en) begin
      lines[set_idx][{wr_word, 5'd0} +: 32] <= wr_data;
    end
  end
endmodule

module cache_2way_wb #(
  parameter int          ADDR_W    = 30,
  parameter int          SET_BITS  = 2,
  parameter int          WORD_BITS = 2,
  parameter logic [31:0] NOP_WORD  = 32'h13000000
) (
  input  logic                        clk,
  input  logic                        proc_reset,
  input  logic                        proc_read,
  input  logic                        proc_write,
  input  logic [ADDR_W-1:0]           proc_addr,
  input  logic [31:0]                 proc_wdata,
  output logic                        proc_stall,
  output logic [31:0]                 proc_rdata,
  output logic                        mem_read,
  output logic                        mem_write,
  output logic [ADDR_W-WORD_BITS-1:0] mem_addr,
  input  logic [(32<<WORD_BITS)-1:0]  mem_rdata,
  output logic [(32<<WORD_BITS)-1:0]  mem_wdata,
  input  logic                        mem_ready
);
  localparam int TAG_W  = ADDR_W - SET_BITS - WORD_BITS;
  localparam int SETS   = 1 << SET_BITS;
  localparam int LINE_W = 32 << WORD_BITS;

  typedef enum logic [1:0] {CMP, WB, FILL} state_t;
  state_t state;

  logic [TAG_W-1:0]     tag_f;
  logic [SET_BITS-1:0]  set_f;
  logic [WORD_BITS-1:0] word_f;
  assign tag_f  = proc_addr[ADDR_W-1:SET_BITS+WORD_BITS];
  assign set_f  = proc_addr[SET_BITS+WORD_BITS-1:WORD_BITS];
  assign word_f = proc_addr[WORD_BITS-1:0];

  logic [1:0]             w_valid, w_dirty, hit_v, fill_en, clean_en, wr_en;
  logic [1:0][TAG_W-1:0]  w_tag;
  logic [1:0][LINE_W-1:0] w_line;
  logic [SETS-1:0]        lru;

  for (genvar w = 0; w < 2; w++) begin : g_way
    cache_2way_wb_way #(
      .SET_BITS(SET_BITS), .WORD_BITS(WORD_BITS), .TAG_W(TAG_W), .LINE_W(LINE_W)
    ) u_way (
      .clk      (clk),
      .rst      (proc_reset),
      .set_idx  (set_f),
      .valid    (w_valid[w]),
      .dirty    (w_dirty[w]),
      .tag      (w_tag[w]),
      .line     (w_line[w]),
      .fill_en  (fill_en[w]),
      .fill_tag (tag_f),
      .fill_line(mem_rdata),
      .clean_en (clean_en[w]),
      .wr_en    (wr_en[w]),
      .wr_word  (word_f),
      .wr_data  (proc_wdata)
    );
    assign hit_v[w] = w_valid[w] && (w_tag[w] == tag_f);
  end

  logic req, hit, hit_way, victim;
  assign req     = proc_read ^ proc_write;
  assign hit     = |hit_v;
  assign hit_way = ~hit_v[0];
  // Address is held during a miss, so the victim is stable across WB and FILL.
  assign victim  = !w_valid[0] ? 1'b0 : (!w_valid[1] ? 1'b1 : lru[set_f]);

  always_comb begin
    proc_stall = 1'b0;
    proc_rdata = NOP_WORD;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_wdata  = '0;
    mem_addr   = proc_addr[ADDR_W-1:WORD_BITS];
    fill_en    = '0;
    clean_en   = '0;
    wr_en      = '0;
    if (!proc_reset) begin
      case (state)
        CMP: if (req) begin
          if (hit) begin
            if (proc_read) proc_rdata = w_line[hit_way][{word_f, 5'd0} +: 32];
            else           wr_en[hit_way] = 1'b1;
          end else begin
            proc_stall = 1'b1;
          end
        end
        WB: begin
          proc_stall       = 1'b1;
          mem_write        = 1'b1;
          mem_addr         = {w_tag[victim], set_f};
          mem_wdata        = w_line[victim];
          clean_en[victim] = mem_ready;
        end
        FILL: begin
          proc_stall      = 1'b1;
          mem_read        = 1'b1;
          fill_en[victim] = mem_ready;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state <= CMP;
      lru   <= '0;
    end else begin
      case (state)
        CMP: if (req) begin
          if (hit) lru[set_f] <= ~hit_way;
          else     state <= (w_valid[victim] && w_dirty[victim]) ? WB : FILL;
        end
        WB:      if (mem_ready) state <= FILL;
        FILL:    if (mem_ready) state <= CMP;
        default: state <= CMP;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_2way_wb.sv
// Bench for cache_2way_wb: cold-state vector table, directed miss/eviction/reset sequences,
// then random traffic checked against a transparent-memory + per-set recency-list model.
module tb_cache_2way_wb;
  localparam logic [31:0] NOP = 32'h13000000;

  logic         clk = 1'b0;
  logic         proc_reset, proc_read, proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata, proc_rdata;
  logic         proc_stall, mem_read, mem_write, mem_ready;
  logic [27:0]  mem_addr;
  logic [127:0] mem_rdata, mem_wdata;

  always #5 clk = ~clk;

  cache_2way_wb dut (
    .clk(clk), .proc_reset(proc_reset), .proc_read(proc_read), .proc_write(proc_write),
    .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_stall(proc_stall),
    .proc_rdata(proc_rdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .mem_ready(mem_ready)
  );

  int n_cmp = 0, n_bad = 0;
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Memory: 1-cycle mem_ready pulse after wait_n wait cycles.
  logic [127:0] mem_store [64];
  int wait_n = 0, cnt = 0;
  bit resp_en = 0;
  initial forever begin
    @(posedge clk); #2;
    mem_ready = 1'b0;
    if (resp_en && (mem_read || mem_write) && !proc_reset) begin
      if (cnt >= wait_n) begin
        mem_ready = 1'b1;
        cnt = 0;
        if (mem_write) mem_store[mem_addr[5:0]] = mem_wdata;
        else           mem_rdata = mem_store[mem_addr[5:0]];
      end else cnt++;
    end else cnt = 0;
  end

  bit           saw_wr, saw_rd, saw_both;
  logic [27:0]  wr_addr, rd_addr;
  logic [127:0] wr_data;
  int           wb_cyc;

  task automatic do_req(input bit rd, input bit wr, input logic [29:0] a, input logic [31:0] d,
                        output int stalls, output logic [31:0] rdat);
    @(posedge clk); #1;
    proc_read = rd; proc_write = wr; proc_addr = a; proc_wdata = d;
    stalls = 0; saw_wr = 0; saw_rd = 0; saw_both = 0; wb_cyc = 0; rdat = '0;
    forever begin
      @(negedge clk);
      if (mem_read && mem_write) saw_both = 1;
      if (mem_write) begin
        if (!saw_wr) begin wr_addr = mem_addr; wr_data = mem_wdata; end
        saw_wr = 1; wb_cyc++;
      end
      if (mem_read && !saw_rd) begin saw_rd = 1; rd_addr = mem_addr; end
      if (!proc_stall) begin rdat = proc_rdata; break; end
      stalls++;
      if (stalls > 200) begin check("req_timeout", 1, 0); break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    proc_reset = 1'b1; proc_read = 1'b0; proc_write = 1'b0;
    @(negedge clk);
    proc_reset = 1'b0;
  endtask

  typedef struct {
    bit rd, wr; logic [29:0] addr; logic [31:0] wdata;
    bit stall; logic [31:0] rdata; bit mrd, mwr; logic [27:0] maddr;
  } vec_t;
  vec_t tbl [5];

  typedef struct { int tag; bit dirty; } ent_t;
  ent_t mq [4][$];
  logic [31:0] ref_mem [256];

  int s;
  logic [31:0] r;

  initial begin
    proc_reset = 1'b1; proc_read = 1'b0; proc_write = 1'b0; proc_addr = '0; proc_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 64; i++)
      for (int k = 0; k < 4; k++) mem_store[i][k*32 +: 32] = 32'h10000000 + i*4 + k;
    mem_store[4] = 128'h44444444_33333333_22222222_11111111;

    // Cold cache, memory never answers: FILL holds.
    tbl[0] = '{0, 0, 30'h10, 32'h0,        0, NOP, 0, 0, 28'h4};
    tbl[1] = '{1, 1, 30'h23, 32'h12345678, 0, NOP, 0, 0, 28'h8};
    tbl[2] = '{1, 0, 30'h10, 32'h0,        1, NOP, 0, 0, 28'h4};
    tbl[3] = '{1, 0, 30'h10, 32'h0,        1, NOP, 1, 0, 28'h4};
    tbl[4] = '{1, 0, 30'h10, 32'h0,        1, NOP, 1, 0, 28'h4};
    repeat (2) @(posedge clk);
    #1 proc_reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      proc_read = tbl[i].rd; proc_write = tbl[i].wr; proc_addr = tbl[i].addr; proc_wdata = tbl[i].wdata;
      @(negedge clk);
      check($sformatf("tbl%0d_stall", i), proc_stall, tbl[i].stall);
      check($sformatf("tbl%0d_rdata", i), proc_rdata, tbl[i].rdata);
      check($sformatf("tbl%0d_mread", i), mem_read, tbl[i].mrd);
      check($sformatf("tbl%0d_mwrite", i), mem_write, tbl[i].mwr);
      check($sformatf("tbl%0d_maddr", i), mem_addr, tbl[i].maddr);
    end
    do_reset();
    resp_en = 1;

    // Cold read with 3 wait cycles.
    wait_n = 3;
    do_req(1, 0, 30'h10, 0, s, r);
    check("cold_stalls", s, 5);
    check("cold_rdata", r, 32'h11111111);
    check("cold_fill_addr", rd_addr, 28'h4);
    check("cold_no_wb", saw_wr, 0);

    // Associativity and LRU replacement in set 0.
    wait_n = 1;
    do_req(1, 0, 30'h00, 0, s, r); check("a00_miss", s, 3); check("a00_rdata", r, 32'h10000000);
    do_req(1, 0, 30'h00, 0, s, r); check("a00_hit", s, 0);
    do_req(1, 0, 30'h10, 0, s, r); check("a10_hit", s, 0); check("a10_rdata", r, 32'h11111111);
    do_req(1, 0, 30'h20, 0, s, r); check("a20_miss", s, 3); check("a20_no_wb", saw_wr, 0);
    check("a20_rdata", r, 32'h10000020);
    do_req(1, 0, 30'h10, 0, s, r); check("a10_kept", s, 0);
    do_req(1, 0, 30'h00, 0, s, r); check("a00_evicted", s, 3);

    // Dirty eviction: write-back of 0x00 line, then fill of 0x20.
    wait_n = 3;
    do_req(0, 1, 30'h01, 32'hDEADBEEF, s, r); check("d_wr_hit", s, 0); check("d_wr_rdata", r, NOP);
    do_req(1, 0, 30'h10, 0, s, r); check("d_touch", s, 0);
    do_req(1, 0, 30'h20, 0, s, r);
    check("d_stalls", s, 9);
    check("d_wb_seen", saw_wr, 1);
    check("d_wb_addr", wr_addr, 28'h0);
    check("d_wb_word1", wr_data[63:32], 32'hDEADBEEF);
    check("d_wb_cycles", wb_cyc, 4);
    check("d_fill_addr", rd_addr, 28'h8);
    check("d_no_overlap", saw_both, 0);
    check("d_rdata", r, 32'h10000020);
    do_req(1, 0, 30'h01, 0, s, r); check("d_refill_stalls", s, 5); check("d_refill_rdata", r, 32'hDEADBEEF);

    // Both request lines high is not a request.
    @(posedge clk); #1;
    proc_read = 1; proc_write = 1; proc_addr = 30'h21; proc_wdata = 32'h55555555;
    @(negedge clk);
    check("ill_stall", proc_stall, 0); check("ill_mread", mem_read, 0);
    check("ill_mwrite", mem_write, 0); check("ill_rdata", proc_rdata, NOP);
    do_req(1, 0, 30'h21, 0, s, r); check("ill_after_hit", s, 0); check("ill_after_rdata", r, 32'h10000021);

    // Reset in the middle of a fill.
    wait_n = 20;
    @(posedge clk); #1;
    proc_read = 1; proc_write = 0; proc_addr = 30'h30;
    begin
      int k = 0;
      do begin @(negedge clk); k++; end while (!mem_read && k < 10);
      check("rst_fill_reached", mem_read, 1);
    end
    proc_reset = 1'b1;
    #1;
    check("rst_mread", mem_read, 0); check("rst_stall", proc_stall, 0);
    check("rst_mwrite", mem_write, 0); check("rst_rdata", proc_rdata, NOP);
    proc_read = 0;
    @(negedge clk);
    proc_reset = 1'b0;

    // Zero-wait memory: miss costs exactly 2 stall cycles.
    wait_n = 0;
    do_req(1, 0, 30'h30, 0, s, r); check("zw_stalls", s, 2); check("zw_rdata", r, 32'h10000030);
    do_req(1, 0, 30'h21, 0, s, r); check("zw_cold_again", s, 2);

    // Random traffic against the model.
    do_reset();
    for (int a = 0; a < 256; a++) begin
      logic [127:0] ln;
      ln = mem_store[a >> 2];
      ref_mem[a] = ln[(a & 3)*32 +: 32];
    end
    for (int it = 0; it < 400; it++) begin
      if ($urandom % 10 == 0) begin
        bit both;
        both = 1'($urandom % 2);
        @(posedge clk); #1;
        proc_read = both; proc_write = both; proc_addr = 30'($urandom % 128); proc_wdata = $urandom;
        @(negedge clk);
        check("rnd_noreq_stall", proc_stall, 0);
        check("rnd_noreq_mem", {mem_read, mem_write}, 2'b00);
      end else begin
        int a, st, tg, idx, exp_s;
        bit wr, exp_wb;
        logic [31:0] d;
        ent_t e;
        a = $urandom % 128; wr = ($urandom % 3 == 0); d = $urandom; wait_n = $urandom % 3;
        st = (a >> 2) & 3; tg = a >> 4; idx = -1; exp_wb = 0;
        for (int j = 0; j < mq[st].size(); j++) if (mq[st][j].tag == tg) idx = j;
        if (idx >= 0) begin
          exp_s = 0;
          e = mq[st][idx];
          mq[st].delete(idx);
        end else begin
          if (mq[st].size() == 2) begin
            exp_wb = mq[st][1].dirty;
            void'(mq[st].pop_back());
          end
          exp_s = exp_wb ? 2*(wait_n+1) + 1 : wait_n + 2;
          e.tag = tg; e.dirty = 0;
        end
        e.dirty = e.dirty | wr;
        mq[st].push_front(e);
        do_req(!wr, wr, 30'(a), d, s, r);
        check($sformatf("rnd%0d_stalls", it), s, exp_s);
        check($sformatf("rnd%0d_wb", it), saw_wr, exp_wb);
        check($sformatf("rnd%0d_overlap", it), saw_both, 0);
        if (wr) begin
          check($sformatf("rnd%0d_wr_rdata", it), r, NOP);
          ref_mem[a] = d;
        end else begin
          check($sformatf("rnd%0d_rdata", it), r, ref_mem[a]);
        end
      end
    end

    @(posedge clk); #1;
    proc_read = 0; proc_write = 0;
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
